// File: rtl/rv32i_pipe_pkg.sv
// Shared pipeline definitions: hazard FSM encoding, forwarding selects and default widths.
package rv32i_pipe_pkg;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_REDIR   = 2'd1,
      ST_MEMWAIT = 2'd2
   } hz_state_t;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   localparam int REG_INX_WTH_DEF = 5;

endpackage

// File: rtl/rv32i_hazard_ctrl_if.sv
// Hazard controller bundle: stage register indices/enables in, hold/flush/forward controls out.
interface rv32i_hazard_ctrl_if #(
   parameter int REG_INX_WTH = 5,
   parameter int CNT_WTH     = 32
);
   logic [REG_INX_WTH-1:0] id_src1_inx_i;
   logic [REG_INX_WTH-1:0] id_src2_inx_i;
   logic [REG_INX_WTH-1:0] ex_src1_inx_i;
   logic [REG_INX_WTH-1:0] ex_src2_inx_i;
   logic [REG_INX_WTH-1:0] ex_rd_inx_i;
   logic                   ex_RegW_EN_i;
   logic                   ex_is_lw_i;
   logic [REG_INX_WTH-1:0] mem_rd_inx_i;
   logic                   mem_RegW_EN_i;
   logic [REG_INX_WTH-1:0] wb_rd_inx_i;
   logic                   wb_RegW_EN_i;
   logic                   ex_redirect_i;
   logic                   dmem_req_i;
   logic                   dmem_ready_i;
   logic                   if_hold_o;
   logic                   pipe_hold_o;
   logic                   id_flush_o;
   logic [1:0]             fwd_src1_sel_o;
   logic [1:0]             fwd_src2_sel_o;
   logic [CNT_WTH-1:0]     stall_cnt_o;
   logic [CNT_WTH-1:0]     flush_cnt_o;
   logic [1:0]             state_o;

   modport master (
      output id_src1_inx_i, id_src2_inx_i, ex_src1_inx_i, ex_src2_inx_i,
             ex_rd_inx_i, ex_RegW_EN_i, ex_is_lw_i, mem_rd_inx_i, mem_RegW_EN_i,
             wb_rd_inx_i, wb_RegW_EN_i, ex_redirect_i, dmem_req_i, dmem_ready_i,
      input  if_hold_o, pipe_hold_o, id_flush_o, fwd_src1_sel_o, fwd_src2_sel_o,
             stall_cnt_o, flush_cnt_o, state_o
   );

   modport slave (
      input  id_src1_inx_i, id_src2_inx_i, ex_src1_inx_i, ex_src2_inx_i,
             ex_rd_inx_i, ex_RegW_EN_i, ex_is_lw_i, mem_rd_inx_i, mem_RegW_EN_i,
             wb_rd_inx_i, wb_RegW_EN_i, ex_redirect_i, dmem_req_i, dmem_ready_i,
      output if_hold_o, pipe_hold_o, id_flush_o, fwd_src1_sel_o, fwd_src2_sel_o,
             stall_cnt_o, flush_cnt_o, state_o
   );
endinterface

// File: rtl/rv32i_sat_cnt.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module rv32i_sat_cnt #(
   parameter int WTH = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           inc,
   input  logic           clear,
   output logic [WTH-1:0] cnt
);
   localparam logic [WTH-1:0] ONE = WTH'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + ONE;
      end
   end
endmodule

// File: rtl/rv32i_hazard_ctrl.sv
// Five-stage RV32I hazard controller: load-use bubbles, redirect squashes, dmem freezes, EX forwarding.
//   state      | meaning
//   ST_RUN     | normal flow; redirect or load-use handled in the current cycle
//   ST_REDIR   | squashing wrong-path fetches, rcnt cycles remaining
//   ST_MEMWAIT | frozen on data memory; ret_redir says where to resume
module rv32i_hazard_ctrl
   import rv32i_pipe_pkg::*;
#(
   parameter int REG_INX_WTH  = REG_INX_WTH_DEF,
   parameter int REDIRECT_CYC = 2,
   parameter int CNT_WTH      = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   rv32i_hazard_ctrl_if.slave  hz
);
   localparam int RCNT_WTH = (REDIRECT_CYC > 1) ? $clog2(REDIRECT_CYC) : 1;
   localparam logic [RCNT_WTH-1:0] RCNT_LOAD = RCNT_WTH'((REDIRECT_CYC > 1) ? REDIRECT_CYC - 1 : 0);
   localparam logic [RCNT_WTH-1:0] RCNT_ONE  = RCNT_WTH'(1);

   hz_state_t           state, state_nxt, eff_state;
   logic                ret_redir, ret_redir_nxt;
   logic [RCNT_WTH-1:0] rcnt, rcnt_nxt;
   logic                mem_busy, load_use;
   logic                if_hold, pipe_hold, flush;

   function automatic logic [1:0] fwd_sel(
      input logic [REG_INX_WTH-1:0] src,
      input logic [REG_INX_WTH-1:0] mem_rd,
      input logic                   mem_en,
      input logic [REG_INX_WTH-1:0] wb_rd,
      input logic                   wb_en
   );
      if (mem_en && (mem_rd != '0) && (mem_rd == src)) return FWD_MEM;
      if (wb_en && (wb_rd != '0) && (wb_rd == src))    return FWD_WB;
      return FWD_REG;
   endfunction

   assign mem_busy = hz.dmem_req_i & ~hz.dmem_ready_i;
   assign load_use = hz.ex_is_lw_i & hz.ex_RegW_EN_i & (hz.ex_rd_inx_i != '0) &
                     ((hz.ex_rd_inx_i == hz.id_src1_inx_i) | (hz.ex_rd_inx_i == hz.id_src2_inx_i));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_RUN;
         ret_redir <= 1'b0;
         rcnt      <= '0;
      end else begin
         state     <= state_nxt;
         ret_redir <= ret_redir_nxt;
         rcnt      <= rcnt_nxt;
      end
   end

   // Leaving MEMWAIT behaves as the resumed state in the same cycle, so no
   // unflushed bubble slips through between the freeze and the squash.
   always_comb begin
      state_nxt     = state;
      ret_redir_nxt = ret_redir;
      rcnt_nxt      = rcnt;
      if_hold       = 1'b0;
      pipe_hold     = 1'b0;
      flush         = 1'b0;
      eff_state     = state;
      if (state == ST_MEMWAIT) eff_state = ret_redir ? ST_REDIR : ST_RUN;

      if (mem_busy) begin
         if_hold   = 1'b1;
         pipe_hold = 1'b1;
         state_nxt = ST_MEMWAIT;
         if (state != ST_MEMWAIT) ret_redir_nxt = (state == ST_REDIR);
      end else begin
         state_nxt = eff_state;
         case (eff_state)
            ST_REDIR: begin
               flush    = 1'b1;
               rcnt_nxt = rcnt - RCNT_ONE;
               if (rcnt == RCNT_ONE) state_nxt = ST_RUN;
            end
            default: begin
               if (hz.ex_redirect_i) begin
                  flush = 1'b1;
                  if (REDIRECT_CYC > 1) begin
                     state_nxt = ST_REDIR;
                     rcnt_nxt  = RCNT_LOAD;
                  end
               end else if (load_use) begin
                  if_hold = 1'b1;
                  flush   = 1'b1;
               end
            end
         endcase
      end
   end

   assign hz.if_hold_o      = rst_n & if_hold;
   assign hz.pipe_hold_o    = rst_n & pipe_hold;
   assign hz.id_flush_o     = rst_n & flush;
   assign hz.fwd_src1_sel_o = rst_n ? fwd_sel(hz.ex_src1_inx_i, hz.mem_rd_inx_i, hz.mem_RegW_EN_i,
                                              hz.wb_rd_inx_i, hz.wb_RegW_EN_i) : FWD_REG;
   assign hz.fwd_src2_sel_o = rst_n ? fwd_sel(hz.ex_src2_inx_i, hz.mem_rd_inx_i, hz.mem_RegW_EN_i,
                                              hz.wb_rd_inx_i, hz.wb_RegW_EN_i) : FWD_REG;
   assign hz.state_o        = state;

   rv32i_sat_cnt #(.WTH(CNT_WTH)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (hz.if_hold_o),
      .clear (1'b0),
      .cnt   (hz.stall_cnt_o)
   );

   rv32i_sat_cnt #(.WTH(CNT_WTH)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (hz.id_flush_o),
      .clear (1'b0),
      .cnt   (hz.flush_cnt_o)
   );
endmodule

// File: tb/tb_rv32i_hazard_ctrl.sv
// Directed and random stimulus for rv32i_hazard_ctrl, checked against a remaining-squash-count model.
module tb_rv32i_hazard_ctrl;
   localparam int RCYC = 3;
   localparam longint MAXC = 64'hFFFF_FFFF;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_pass = 0;

   // reference model: squash cycles still owed, counters, expected debug state
   int         m_r = 0;
   longint     m_stall = 0;
   longint     m_flush = 0;
   logic [1:0] m_state = 2'd0;

   always #5 clk = ~clk;

   rv32i_hazard_ctrl_if #(.REG_INX_WTH(5), .CNT_WTH(32)) hz ();

   rv32i_hazard_ctrl #(.REG_INX_WTH(5), .REDIRECT_CYC(RCYC), .CNT_WTH(32)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hz)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [1:0] ref_fwd(input int src, input int mrd, input bit men,
                                          input int wrd, input bit wen);
      if (men && mrd != 0 && mrd == src) return 2'b01;
      if (wen && wrd != 0 && wrd == src) return 2'b10;
      return 2'b00;
   endfunction

   task automatic idle();
      hz.id_src1_inx_i = '0; hz.id_src2_inx_i = '0;
      hz.ex_src1_inx_i = '0; hz.ex_src2_inx_i = '0;
      hz.ex_rd_inx_i = '0;   hz.ex_RegW_EN_i = 1'b0; hz.ex_is_lw_i = 1'b0;
      hz.mem_rd_inx_i = '0;  hz.mem_RegW_EN_i = 1'b0;
      hz.wb_rd_inx_i = '0;   hz.wb_RegW_EN_i = 1'b0;
      hz.ex_redirect_i = 1'b0;
      hz.dmem_req_i = 1'b0;  hz.dmem_ready_i = 1'b1;
   endtask

   task automatic model_reset();
      m_r = 0; m_stall = 0; m_flush = 0; m_state = 2'd0;
   endtask

   // Inputs are applied at negedge; outputs are checked 1 ns later, model advances at posedge.
   task automatic cycle(input string tag);
      bit   busy, lu;
      logic e_ifh, e_ph, e_fl;
      int   r_n;
      #1;
      busy = hz.dmem_req_i && !hz.dmem_ready_i;
      lu   = hz.ex_is_lw_i && hz.ex_RegW_EN_i && hz.ex_rd_inx_i != 0 &&
             (hz.ex_rd_inx_i == hz.id_src1_inx_i || hz.ex_rd_inx_i == hz.id_src2_inx_i);
      e_ifh = 1'b0; e_ph = 1'b0; e_fl = 1'b0; r_n = m_r;
      if (busy) begin
         e_ifh = 1'b1; e_ph = 1'b1;
      end else if (m_r > 0) begin
         e_fl = 1'b1; r_n = m_r - 1;
      end else if (hz.ex_redirect_i) begin
         e_fl = 1'b1; r_n = RCYC - 1;
      end else if (lu) begin
         e_ifh = 1'b1; e_fl = 1'b1;
      end
      chk({tag, "/if_hold"},   32'(hz.if_hold_o),   32'(e_ifh));
      chk({tag, "/pipe_hold"}, 32'(hz.pipe_hold_o), 32'(e_ph));
      chk({tag, "/flush"},     32'(hz.id_flush_o),  32'(e_fl));
      chk({tag, "/fwd1"}, 32'(hz.fwd_src1_sel_o),
          32'(ref_fwd(hz.ex_src1_inx_i, hz.mem_rd_inx_i, hz.mem_RegW_EN_i, hz.wb_rd_inx_i, hz.wb_RegW_EN_i)));
      chk({tag, "/fwd2"}, 32'(hz.fwd_src2_sel_o),
          32'(ref_fwd(hz.ex_src2_inx_i, hz.mem_rd_inx_i, hz.mem_RegW_EN_i, hz.wb_rd_inx_i, hz.wb_RegW_EN_i)));
      chk({tag, "/state"},     32'(hz.state_o),     32'(m_state));
      chk({tag, "/stall_cnt"}, hz.stall_cnt_o,      32'(m_stall));
      chk({tag, "/flush_cnt"}, hz.flush_cnt_o,      32'(m_flush));
      @(posedge clk);
      if (e_ifh && m_stall != MAXC) m_stall++;
      if (e_fl && m_flush != MAXC)  m_flush++;
      m_r     = r_n;
      m_state = busy ? 2'd2 : ((r_n > 0) ? 2'd1 : 2'd0);
      @(negedge clk);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "/if_hold"},   32'(hz.if_hold_o),      32'd0);
      chk({tag, "/pipe_hold"}, 32'(hz.pipe_hold_o),    32'd0);
      chk({tag, "/flush"},     32'(hz.id_flush_o),     32'd0);
      chk({tag, "/fwd1"},      32'(hz.fwd_src1_sel_o), 32'd0);
      chk({tag, "/state"},     32'(hz.state_o),        32'd0);
      chk({tag, "/stall_cnt"}, hz.stall_cnt_o,         32'd0);
      chk({tag, "/flush_cnt"}, hz.flush_cnt_o,         32'd0);
   endtask

   initial begin
      // reset with busy memory and a forwarding match on the inputs: all outputs must stay 0
      idle();
      hz.dmem_req_i = 1'b1; hz.dmem_ready_i = 1'b0;
      hz.mem_rd_inx_i = 5'd7; hz.mem_RegW_EN_i = 1'b1; hz.ex_src1_inx_i = 5'd7;
      #12;
      chk_reset_outputs("reset");
      @(negedge clk);
      idle();
      rst_n = 1'b1;
      model_reset();
      cycle("idle0");

      // load-use on src2
      hz.ex_is_lw_i = 1'b1; hz.ex_RegW_EN_i = 1'b1; hz.ex_rd_inx_i = 5'd5; hz.id_src2_inx_i = 5'd5;
      cycle("lu");
      hz.ex_is_lw_i = 1'b0;
      cycle("lu_clear");
      chk("lu/stall_cnt_is_1", hz.stall_cnt_o, 32'd1);
      chk("lu/flush_cnt_is_1", hz.flush_cnt_o, 32'd1);

      // load-use suppressed by x0 destination, then by RegW disabled
      hz.ex_is_lw_i = 1'b1; hz.ex_rd_inx_i = 5'd0; hz.id_src2_inx_i = 5'd0;
      cycle("lu_x0");
      hz.ex_rd_inx_i = 5'd9; hz.id_src1_inx_i = 5'd9; hz.ex_RegW_EN_i = 1'b0;
      cycle("lu_nowe");
      chk("lu_none/stall_cnt", hz.stall_cnt_o, 32'd1);
      idle();

      // forwarding priority then x0 suppression
      hz.mem_rd_inx_i = 5'd7; hz.wb_rd_inx_i = 5'd7; hz.ex_src1_inx_i = 5'd7;
      hz.mem_RegW_EN_i = 1'b1; hz.wb_RegW_EN_i = 1'b1;
      #1 chk("fwd_prio", 32'(hz.fwd_src1_sel_o), 32'd1);
      cycle("fwd_prio");
      hz.mem_rd_inx_i = 5'd0; hz.wb_rd_inx_i = 5'd0; hz.ex_src1_inx_i = 5'd0;
      #1 chk("fwd_x0", 32'(hz.fwd_src1_sel_o), 32'd0);
      cycle("fwd_x0");
      idle();

      // redirect pulse: three flush cycles, RUN -> REDIR -> REDIR -> RUN
      hz.ex_redirect_i = 1'b1;
      cycle("redir0");
      hz.ex_redirect_i = 1'b0;
      for (int i = 0; i < 3; i++) cycle("redir");
      chk("redir/back_to_run", 32'(hz.state_o), 32'd0);

      // memory wait starting at the second REDIR cycle
      hz.ex_redirect_i = 1'b1;
      cycle("mw_redir0");
      hz.ex_redirect_i = 1'b0;
      cycle("mw_redir1");
      hz.dmem_req_i = 1'b1; hz.dmem_ready_i = 1'b0;
      for (int i = 0; i < 4; i++) cycle("mw_busy");
      hz.dmem_req_i = 1'b0; hz.dmem_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) cycle("mw_resume");

      // asynchronous reset in the middle of REDIR
      hz.ex_redirect_i = 1'b1;
      cycle("ar_redir0");
      hz.mem_rd_inx_i = 5'd7; hz.mem_RegW_EN_i = 1'b1; hz.ex_src1_inx_i = 5'd7;
      #2 rst_n = 1'b0;
      #1 chk_reset_outputs("async_rst");
      @(negedge clk);
      idle();
      rst_n = 1'b1;
      model_reset();
      cycle("post_rst");

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         hz.id_src1_inx_i = 5'($urandom_range(0, 3));
         hz.id_src2_inx_i = 5'($urandom_range(0, 3));
         hz.ex_src1_inx_i = 5'($urandom_range(0, 3));
         hz.ex_src2_inx_i = 5'($urandom_range(0, 3));
         hz.ex_rd_inx_i   = 5'($urandom_range(0, 3));
         hz.ex_RegW_EN_i  = 1'($urandom_range(0, 1));
         hz.ex_is_lw_i    = ($urandom_range(0, 9) < 4);
         hz.mem_rd_inx_i  = 5'($urandom_range(0, 3));
         hz.mem_RegW_EN_i = 1'($urandom_range(0, 1));
         hz.wb_rd_inx_i   = 5'($urandom_range(0, 3));
         hz.wb_RegW_EN_i  = 1'($urandom_range(0, 1));
         hz.ex_redirect_i = ($urandom_range(0, 99) < 15);
         hz.dmem_req_i    = ($urandom_range(0, 9) < 3);
         hz.dmem_ready_i  = 1'($urandom_range(0, 1));
         cycle("rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/rv32i_hazard_ctrl.md
# rv32i_hazard_ctrl

Pipeline hazard controller for the five-stage RV32I core. It sequences the IF, ID, EX and MEM stage registers:
- one-cycle load-use bubbles,
- multi-cycle squashes after a redirect resolved in EX,
- full-pipeline freezes while data memory has not accepted an access.

It also produces the EX-stage forwarding selects. It keeps two saturating performance counters.

## Interface
Parameters:
- REG_INX_WTH, 5, register index width
- REDIRECT_CYC, 2, cycles `id_flush_o` stays asserted per redirect (≥1); covers fetch latency
- CNT_WTH, 32, performance counter width

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- id_src1_inx_i / id_src2_inx_i  in  REG_INX_WTH  source indices of the instruction in ID (from the decoder, unregistered)
- ex_src1_inx_i / ex_src2_inx_i  in  REG_INX_WTH  source indices in EX
- ex_rd_inx_i  in  REG_INX_WTH; ex_RegW_EN_i  in  1; ex_is_lw_i  in  1  EX destination info
- mem_rd_inx_i  in  REG_INX_WTH; mem_RegW_EN_i  in  1  MEM destination info
- wb_rd_inx_i  in  REG_INX_WTH; wb_RegW_EN_i  in  1  WB destination info
- ex_redirect_i  in  1  taken branch or jump resolved in EX
- dmem_req_i  in  1  MEM stage issuing a data access
- dmem_ready_i  in  1  data memory accepts the access this cycle
- if_hold_o  out  1  hold PC and the IF/ID register
- pipe_hold_o  out  1  hold the ID/EX, EX/MEM and MEM/WB registers
- id_flush_o  out  1  clear the ID/EX register (drives the decoder's flush input)
- fwd_src1_sel_o / fwd_src2_sel_o  out  2  EX operand select: 00 regfile, 01 MEM result, 10 WB data
- stall_cnt_o  out  CNT_WTH  cycles with `if_hold_o` = 1
- flush_cnt_o  out  CNT_WTH  cycles with `id_flush_o` = 1
- state_o  out  2  current FSM state (debug)

## Operation
- Derived conditions:
  - `mem_busy` = `dmem_req_i` & ~`dmem_ready_i`.
  - `load_use` = `ex_is_lw_i` & `ex_RegW_EN_i` & (`ex_rd` ≠ 0) & (`ex_rd` == `id_src1` | `ex_rd` == `id_src2`).
- FSM states: RUN = 0, REDIR = 1, MEMWAIT = 2. A down-counter `rcnt` runs alongside the FSM.
- Priority in every state: `mem_busy` > redirect > `load_use`.
- `mem_busy` (any state):
  - Outputs: `if_hold_o` = `pipe_hold_o` = 1, `id_flush_o` = 0.
  - `rcnt` is frozen and the state goes to MEMWAIT.
  - On the first cycle without `mem_busy`, the state returns to the state it was in before MEMWAIT (RUN or REDIR), held in a 1-bit return register.
  - A redirect pending in EX is deferred; EX is frozen, so it remains asserted.
- RUN, `ex_redirect_i`:
  - `id_flush_o` = 1, `if_hold_o` = 0.
  - If REDIRECT_CYC > 1: next state is REDIR and `rcnt` loads REDIRECT_CYC−1.
- REDIR:
  - `id_flush_o` = 1 and `rcnt` decrements.
  - When `rcnt` = 1, next state is RUN.
  - `ex_redirect_i` and `load_use` are ignored (EX holds bubbles; ID is squashed).
- RUN, `load_use` without redirect: `if_hold_o` = 1 and `id_flush_o` = 1 for exactly one cycle, then the condition clears naturally.
- Forwarding (combinational, per source):
  - Select MEM (01) if `mem_RegW_EN_i` & `mem_rd` ≠ 0 & `mem_rd` == `ex_src`.
  - Otherwise select WB (10) on the same test against WB.
  - Otherwise 00. MEM wins when both match.
- Counters: increment on their condition and saturate at all-ones.

## Timing
- Hold, flush and forwarding outputs are combinational from the inputs and the current state, with zero-cycle latency.
- State, `rcnt` and the counters update on posedge `clk`.
- Redirect at cycle T (RUN, REDIRECT_CYC = 2): `id_flush_o` is 1 at T and T+1; RUN at T+2.
- Reset:
  - Asynchronous assertion at any time, including mid-REDIR or mid-MEMWAIT, forces state RUN, `rcnt` 0, counters 0.
  - While `rst_n` = 0: all hold, flush and fwd outputs are 0, `state_o` = 0.
  - Deassertion takes effect at the next posedge.
- Simultaneous redirect and `load_use` in RUN: redirect only; `if_hold_o` = 0.

## Structure
- Shared package `rv32i_pipe_pkg`:
  - FSM state encoding.
  - FWD_REG/FWD_MEM/FWD_WB select constants.
  - REG_INX_WTH default.
- Sub-module `rv32i_sat_cnt` (parameter width, inputs inc/clear, saturating), instantiated twice for the performance counters.

## Test plan
- Load-use: `lw` with `ex_rd` = 5 and `id_src2` = 5 → one cycle of `if_hold_o` = `id_flush_o` = 1; `stall_cnt_o` = 1, `flush_cnt_o` = 1.
- Forwarding priority: `mem_rd` = `wb_rd` = `ex_src1` = 7, both RegW_EN = 1 → `fwd_src1_sel_o` = 01. Repeat with `mem_rd` = 0 and `wb_rd` = 0 → 00.
- Redirect, REDIRECT_CYC = 3: `ex_redirect_i` pulse → `id_flush_o` high for exactly 3 cycles; state sequence RUN→REDIR→REDIR→RUN.
- Memory wait during REDIR: `dmem_ready_i` low for 4 cycles after cycle 1 of REDIR → holds = 1 and flush = 0 for 4 cycles, then the remaining flush cycles complete.
- `load_use` with `ex_rd` = 0, or `ex_RegW_EN_i` = 0 → no hold, no flush.
- Asynchronous `rst_n` low mid-REDIR (between clock edges) → outputs 0 immediately; counters 0; RUN after release.
